// File: rtl/mem_axi_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_axi_resp_pkg
// Shared types and constants for the AXI4 memory responder:
//   burst_e     - AXI burst encodings (FIXED/INCR/WRAP/RSVD)
//   resp_e      - AXI response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   wr_state_e  - write engine states
//   rd_state_e  - read engine states
//   SIZE_*      - supported beat sizes (1, 2, 4 bytes)
//   WRAP_LEN_*  - AxLEN values that are legal for WRAP bursts
// ---------------------------------------------------------------------------
package mem_axi_resp_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;

    localparam logic [7:0] WRAP_LEN_2  = 8'd1;
    localparam logic [7:0] WRAP_LEN_4  = 8'd3;
    localparam logic [7:0] WRAP_LEN_8  = 8'd7;
    localparam logic [7:0] WRAP_LEN_16 = 8'd15;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == WRAP_LEN_2) || (len == WRAP_LEN_4) ||
               (len == WRAP_LEN_8) || (len == WRAP_LEN_16);
    endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_next
// Combinational AXI burst address sequencer: given the current beat address
// and the burst attributes, produces the address of the next beat and flags
// whether the burst attributes are legal for this memory port.
// Ports:
//   i_addr      current beat byte address
//   i_len       AxLEN (beats - 1)
//   i_size      AxSIZE (log2 bytes per beat)
//   i_burst     AxBURST
//   o_next_addr address of the following beat (modulo 2^ADDR_WIDTH)
//   o_legal     1 when size <= 4 bytes, burst != RSVD, and WRAP length legal
// ---------------------------------------------------------------------------
module axi_burst_addr_next
    import mem_axi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 28
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_legal
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_incr;

    always_comb begin
        w_step = ONE << i_size;
        // Wrap boundary covers the whole burst: (len+1) beats of 2^size bytes.
        w_mask = ((ADDR_WIDTH'(i_len) + ONE) << i_size) - ONE;
        w_incr = i_addr + w_step;

        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
            default:     o_next_addr = w_incr;
        endcase

        o_legal = (i_size inside {SIZE_1B, SIZE_2B, SIZE_4B}) &&
                  (i_burst != BURST_RSVD) &&
                  ((i_burst != BURST_WRAP) || wrap_len_ok(i_len));
    end

endmodule

// File: rtl/mem_axi_responder.sv
// ---------------------------------------------------------------------------
// mem_axi_responder
// AXI4 slave that terminates the SoC DRAM port with an on-chip word array.
// Independent read and write engines, one outstanding burst each; FIXED,
// INCR and WRAP bursts; full read throughput with rready held high.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   s_aw*  (in)  / s_awready     write address channel
//   s_w*   (in)  / s_wready      write data channel
//   s_b*   (out) / s_bready      write response channel
//   s_ar*  (in)  / s_arready     read address channel
//   s_r*   (out) / s_rready      read data channel
// ---------------------------------------------------------------------------
module mem_axi_responder
    import mem_axi_resp_pkg::*;
#(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 28,
    parameter int MEM_WORDS  = 16384
) (
    input  logic                  aclk,
    input  logic                  areset,
    // write address
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    // write data
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int                    IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

    logic [31:0] r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_e             r_wstate, w_wstate_nxt;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic [7:0]            r_wcnt;
    logic                  r_wslv;
    logic                  r_wdec;
    logic [1:0]            r_bresp;

    logic [ADDR_WIDTH-1:0] w_aw_next;
    logic                  w_aw_legal;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wlast_beat;
    logic                  w_w_inrange;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_widx;
    logic [1:0]            w_bresp_fin;

    axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_aw_next (
        .i_addr      (r_awaddr),
        .i_len       (r_awlen),
        .i_size      (r_awsize),
        .i_burst     (r_awburst),
        .o_next_addr (w_aw_next),
        .o_legal     (w_aw_legal)
    );

    always_comb begin
        w_wstate_nxt = r_wstate;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_awready = 1'b1;
                if (s_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                // Beat count alone terminates the burst; wlast is only checked.
                if (s_wvalid && w_wlast_beat) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        if (areset) begin
            s_awready = 1'b0;
            s_wready  = 1'b0;
            s_bvalid  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    assign w_aw_hs      = s_awvalid && s_awready;
    assign w_w_hs       = s_wvalid && s_wready;
    assign w_wlast_beat = (r_wcnt == r_awlen);
    assign w_w_inrange  = (r_awaddr < MEM_BYTES);
    assign w_mem_we     = w_w_hs && w_w_inrange && w_aw_legal;
    assign w_widx       = r_awaddr[IDX_W+1:2];

    // Final response folds in this beat's own wlast/range status.
    assign w_bresp_fin = (!w_aw_legal || r_wslv || (s_wlast != w_wlast_beat)) ? RESP_SLVERR :
                         (r_wdec || !w_w_inrange)                             ? RESP_DECERR :
                                                                                RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (w_aw_hs) begin
            r_awid    <= s_awid;
            r_awaddr  <= s_awaddr;
            r_awlen   <= s_awlen;
            r_awsize  <= s_awsize;
            r_awburst <= s_awburst;
            r_wcnt    <= 8'd0;
            r_wslv    <= 1'b0;
            r_wdec    <= 1'b0;
        end
        if (w_w_hs) begin
            r_awaddr <= w_aw_next;
            r_wcnt   <= r_wcnt + 8'd1;
            if (s_wlast != w_wlast_beat) r_wslv <= 1'b1;
            if (!w_w_inrange)            r_wdec <= 1'b1;
            if (w_wlast_beat)            r_bresp <= w_bresp_fin;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    assign s_bid   = areset ? '0 : r_awid;
    assign s_bresp = areset ? '0 : r_bresp;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_e             r_rstate, w_rstate_nxt;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic [8:0]            r_remain;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [31:0]           r_rdata;
    logic                  r_rzero;

    logic [ADDR_WIDTH-1:0] w_ar_next;
    logic                  w_ar_legal;
    logic                  w_ar_hs;
    logic                  w_rd_en;
    logic                  w_r_inrange;
    logic [IDX_W-1:0]      w_ridx;

    axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_ar_next (
        .i_addr      (r_araddr),
        .i_len       (r_arlen),
        .i_size      (r_arsize),
        .i_burst     (r_arburst),
        .o_next_addr (w_ar_next),
        .o_legal     (w_ar_legal)
    );

    always_comb begin
        w_rstate_nxt = r_rstate;
        s_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_rvalid && s_rready && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (areset) s_arready = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (areset) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    assign w_ar_hs     = s_arvalid && s_arready;
    // Issue a read whenever beats remain and the output register is free
    // or being drained this cycle.
    assign w_rd_en     = (r_rstate == R_DATA) && (r_remain != 9'd0) && (!r_rvalid || s_rready);
    assign w_r_inrange = (r_araddr < MEM_BYTES);
    assign w_ridx      = r_araddr[IDX_W+1:2];

    always_ff @(posedge aclk) begin
        if (areset)        r_rvalid <= 1'b0;
        else if (w_rd_en)  r_rvalid <= 1'b1;
        else if (s_rready) r_rvalid <= 1'b0;
    end

    // Read port kept as a bare registered array read so it maps to block RAM;
    // error beats are zeroed at the output via r_rzero.
    always_ff @(posedge aclk) begin
        if (w_rd_en) r_rdata <= r_mem[w_ridx];
    end

    always_ff @(posedge aclk) begin
        if (w_ar_hs) begin
            r_arid    <= s_arid;
            r_araddr  <= s_araddr;
            r_arlen   <= s_arlen;
            r_arsize  <= s_arsize;
            r_arburst <= s_arburst;
            r_remain  <= {1'b0, s_arlen} + 9'd1;
        end
        if (w_rd_en) begin
            r_rzero  <= !w_ar_legal || !w_r_inrange;
            r_rresp  <= !w_ar_legal  ? RESP_SLVERR :
                        !w_r_inrange ? RESP_DECERR : RESP_OKAY;
            r_rlast  <= (r_remain == 9'd1);
            r_remain <= r_remain - 9'd1;
            r_araddr <= w_ar_next;
        end
    end

    assign s_rvalid = r_rvalid && !areset;
    assign s_rlast  = r_rlast && !areset;
    assign s_rid    = areset ? '0 : r_arid;
    assign s_rresp  = areset ? '0 : r_rresp;
    assign s_rdata  = (areset || r_rzero) ? '0 : r_rdata;

endmodule
